// File: rtl/fwrisc_mem_arbiter_if.sv
// Signal bundle between the fwrisc core's fetch/data ports, the arbiter and external memory.
// The slave modport is the arbiter's view; master is the core-plus-memory environment.
interface fwrisc_mem_arbiter_if;
    logic        i_valid;
    logic [31:0] i_addr;
    logic        i_ready;
    logic [31:0] i_rdata;

    logic        d_valid;
    logic [31:0] d_addr;
    logic        d_write;
    logic [31:0] d_wdata;
    logic [3:0]  d_wstb;
    logic        d_ready;
    logic [31:0] d_rdata;

    logic        m_valid;
    logic [31:0] m_addr;
    logic        m_write;
    logic [31:0] m_wdata;
    logic [3:0]  m_wstb;
    logic [31:0] m_rdata;
    logic        m_ready;

    logic        bus_err;

    modport slave (
        input  i_valid, i_addr,
        output i_ready, i_rdata,
        input  d_valid, d_addr, d_write, d_wdata, d_wstb,
        output d_ready, d_rdata,
        output m_valid, m_addr, m_write, m_wdata, m_wstb,
        input  m_rdata, m_ready,
        output bus_err
    );

    modport master (
        output i_valid, i_addr,
        input  i_ready, i_rdata,
        output d_valid, d_addr, d_write, d_wdata, d_wstb,
        input  d_ready, d_rdata,
        input  m_valid, m_addr, m_write, m_wdata, m_wstb,
        output m_rdata, m_ready,
        input  bus_err
    );
endinterface

// File: rtl/fwrisc_mem_arbiter.sv
// Shares one memory port between the fwrisc fetch and data ports, one transaction at a time,
// with a watchdog that force-completes stalled memory accesses with an error pulse.
module fwrisc_mem_arbiter #(
    parameter int unsigned DATA_PRIORITY = 0,
    parameter int unsigned TIMEOUT       = 255,
    parameter logic [31:0] ERR_RDATA     = 32'hDEADBEEF
) (
    input  logic                 clock,
    input  logic                 reset,
    fwrisc_mem_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, MEM, RESP} state_t;
    typedef enum logic {GRANT_I, GRANT_D} grant_t;

    localparam logic [15:0] TIMEOUT_LAST = (TIMEOUT == 0) ? 16'd0 : 16'(TIMEOUT - 1);

    state_t      state_q, state_d;
    grant_t      grant_q, grant_d;
    grant_t      last_grant_q, last_grant_d;
    grant_t      winner;

    logic        m_valid_q, m_valid_d;
    logic [31:0] m_addr_q, m_addr_d;
    logic        m_write_q, m_write_d;
    logic [31:0] m_wdata_q, m_wdata_d;
    logic [3:0]  m_wstb_q, m_wstb_d;
    logic [31:0] i_rdata_q, i_rdata_d;
    logic [31:0] d_rdata_q, d_rdata_d;
    logic        err_q, err_d;
    logic [15:0] wdog_q, wdog_d;

    logic        timeout_hit;
    logic [31:0] resp_data;

    // On simultaneous requests the loser of the previous arbitration goes first unless D is fixed-priority.
    always_comb begin
        if (bus.i_valid && bus.d_valid) begin
            winner = (DATA_PRIORITY != 0 || last_grant_q == GRANT_I) ? GRANT_D : GRANT_I;
        end else if (bus.d_valid) begin
            winner = GRANT_D;
        end else begin
            winner = GRANT_I;
        end
    end

    assign timeout_hit = (TIMEOUT != 0) && (wdog_q == TIMEOUT_LAST);
    assign resp_data   = bus.m_ready ? bus.m_rdata : ERR_RDATA;

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        m_valid_d    = m_valid_q;
        m_addr_d     = m_addr_q;
        m_write_d    = m_write_q;
        m_wdata_d    = m_wdata_q;
        m_wstb_d     = m_wstb_q;
        i_rdata_d    = i_rdata_q;
        d_rdata_d    = d_rdata_q;
        err_d        = err_q;
        wdog_d       = wdog_q;

        case (state_q)
            IDLE: begin
                if (bus.i_valid || bus.d_valid) begin
                    state_d      = MEM;
                    grant_d      = winner;
                    last_grant_d = winner;
                    m_valid_d    = 1'b1;
                    err_d        = 1'b0;
                    wdog_d       = '0;
                    if (winner == GRANT_D) begin
                        m_addr_d  = bus.d_addr;
                        m_write_d = bus.d_write;
                        m_wdata_d = bus.d_wdata;
                        m_wstb_d  = bus.d_wstb;
                    end else begin
                        m_addr_d  = bus.i_addr;
                        m_write_d = 1'b0;
                        m_wdata_d = '0;
                        m_wstb_d  = '0;
                    end
                end
            end
            MEM: begin
                if (bus.m_ready || timeout_hit) begin
                    state_d   = RESP;
                    m_valid_d = 1'b0;
                    err_d     = !bus.m_ready;
                    if (grant_q == GRANT_D) begin
                        d_rdata_d = resp_data;
                    end else begin
                        i_rdata_d = resp_data;
                    end
                end else if (wdog_q != '1) begin
                    wdog_d = wdog_q + 16'd1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            grant_q      <= GRANT_I;
            last_grant_q <= GRANT_I;
            m_valid_q    <= 1'b0;
            m_addr_q     <= '0;
            m_write_q    <= 1'b0;
            m_wdata_q    <= '0;
            m_wstb_q     <= '0;
            i_rdata_q    <= '0;
            d_rdata_q    <= '0;
            err_q        <= 1'b0;
            wdog_q       <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            m_valid_q    <= m_valid_d;
            m_addr_q     <= m_addr_d;
            m_write_q    <= m_write_d;
            m_wdata_q    <= m_wdata_d;
            m_wstb_q     <= m_wstb_d;
            i_rdata_q    <= i_rdata_d;
            d_rdata_q    <= d_rdata_d;
            err_q        <= err_d;
            wdog_q       <= wdog_d;
        end
    end

    // Ready and error pulses are decoded from the one-cycle RESP state.
    assign bus.i_ready = (state_q == RESP) && (grant_q == GRANT_I);
    assign bus.d_ready = (state_q == RESP) && (grant_q == GRANT_D);
    assign bus.bus_err = (state_q == RESP) && err_q;

    assign bus.i_rdata = i_rdata_q;
    assign bus.d_rdata = d_rdata_q;
    assign bus.m_valid = m_valid_q;
    assign bus.m_addr  = m_addr_q;
    assign bus.m_write = m_write_q;
    assign bus.m_wdata = m_wdata_q;
    assign bus.m_wstb  = m_wstb_q;

endmodule

// File: tb/tb_fwrisc_mem_arbiter.sv
// Scoreboard bench for fwrisc_mem_arbiter: directed transactions push expected memory requests
// and responses; monitors pop and compare as the DUT presents them.
module tb_fwrisc_mem_arbiter;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    fwrisc_mem_arbiter_if bus0 ();
    fwrisc_mem_arbiter_if bus1 ();

    fwrisc_mem_arbiter #(
        .DATA_PRIORITY(0),
        .TIMEOUT(8),
        .ERR_RDATA(32'hDEADBEEF)
    ) dut0 (
        .clock(clock),
        .reset(reset),
        .bus(bus0.slave)
    );

    fwrisc_mem_arbiter #(
        .DATA_PRIORITY(1),
        .TIMEOUT(8),
        .ERR_RDATA(32'hDEADBEEF)
    ) dut1 (
        .clock(clock),
        .reset(reset),
        .bus(bus1.slave)
    );

    typedef struct packed {
        logic [31:0] addr;
        logic        write;
        logic [31:0] wdata;
        logic [3:0]  wstb;
    } req_t;

    typedef struct packed {
        logic        is_d;
        logic [31:0] rdata;
        logic        err;
        logic [7:0]  lat;
    } rsp_t;

    req_t        req_q[$];
    rsp_t        rsp_q[$];
    logic [31:0] p1_q[$];

    int total = 0;
    int bad   = 0;

    int          mem_wait     = 0;
    logic [31:0] mem_rdata    = '0;
    bit          rd_from_addr = 1'b0;
    bit          force_rdy    = 1'b0;

    function automatic void check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    function automatic void fail_now(input string name, input string what);
        total++;
        bad++;
        $display("FAIL %s: %s", name, what);
    endfunction

    function automatic void expect_txn(input logic [31:0] addr, input logic wr, input logic [31:0] wdata,
                                       input logic [3:0] wstb, input logic is_d, input logic [31:0] rdata,
                                       input logic err, input logic [7:0] lat);
        req_t r;
        rsp_t s;
        r.addr  = addr;
        r.write = wr;
        r.wdata = wdata;
        r.wstb  = wstb;
        s.is_d  = is_d;
        s.rdata = rdata;
        s.err   = err;
        s.lat   = lat;
        req_q.push_back(r);
        rsp_q.push_back(s);
    endfunction

    // Memory model for dut0: answers after mem_wait cycles of m_valid, never when mem_wait < 0.
    initial begin
        int wcnt;
        wcnt = 0;
        bus0.m_ready = 1'b0;
        bus0.m_rdata = '0;
        forever begin
            @(negedge clock);
            if (reset || !bus0.m_valid) begin
                wcnt = 0;
                bus0.m_ready = force_rdy;
            end else begin
                if (mem_wait >= 0 && wcnt == mem_wait) begin
                    bus0.m_ready = 1'b1;
                    bus0.m_rdata = rd_from_addr ? (bus0.m_addr ^ 32'h5A5A0000) : mem_rdata;
                end else begin
                    bus0.m_ready = force_rdy;
                end
                wcnt++;
            end
        end
    end

    // Zero-wait memory for dut1.
    initial begin
        bus1.m_ready = 1'b0;
        bus1.m_rdata = '0;
        forever begin
            @(negedge clock);
            bus1.m_ready = bus1.m_valid;
            bus1.m_rdata = bus1.m_addr ^ 32'h5A5A0000;
        end
    end

    // dut0 monitor: request-side and response-side scoreboards.
    initial begin
        req_t        cur;
        rsp_t        e;
        logic        prev_mv;
        logic [7:0]  mv_cnt;
        logic [31:0] rd;
        prev_mv = 1'b0;
        mv_cnt  = '0;
        cur     = '0;
        forever begin
            @(negedge clock);
            if (reset) begin
                prev_mv = 1'b0;
                mv_cnt  = '0;
            end else begin
                if (bus0.m_valid) begin
                    if (!prev_mv) begin
                        if (req_q.size() == 0) begin
                            fail_now("req_unexpected", $sformatf("m_valid with addr %0h, none expected", bus0.m_addr));
                        end else begin
                            cur = req_q.pop_front();
                            check("m_addr", bus0.m_addr, cur.addr);
                            check("m_ctl", {bus0.m_write, bus0.m_wstb, bus0.m_wdata}, {cur.write, cur.wstb, cur.wdata});
                        end
                    end else begin
                        check("m_stable", {bus0.m_addr, bus0.m_write, bus0.m_wdata, bus0.m_wstb}, cur);
                    end
                    mv_cnt = mv_cnt + 8'd1;
                end
                if (bus0.i_ready || bus0.d_ready) begin
                    rd = bus0.d_ready ? bus0.d_rdata : bus0.i_rdata;
                    if (rsp_q.size() == 0) begin
                        fail_now("rsp_unexpected", $sformatf("i_ready=%0b d_ready=%0b, none expected", bus0.i_ready, bus0.d_ready));
                    end else begin
                        e = rsp_q.pop_front();
                        check("rsp", {bus0.i_ready, bus0.d_ready, bus0.bus_err, rd}, {~e.is_d, e.is_d, e.err, e.rdata});
                        check("lat", {prev_mv, mv_cnt}, {1'b1, e.lat});
                    end
                    mv_cnt = '0;
                end else if (bus0.bus_err) begin
                    check("bus_err_alone", bus0.bus_err, 1'b0);
                end
                prev_mv = bus0.m_valid;
            end
        end
    end

    // dut1 monitor: fixed data priority must never grant the fetch port while D is held.
    initial begin
        logic        prev_mv;
        logic [31:0] exp;
        prev_mv = 1'b0;
        forever begin
            @(negedge clock);
            if (reset) begin
                prev_mv = 1'b0;
            end else begin
                if (bus1.m_valid && !prev_mv) begin
                    check("p1_m_addr", bus1.m_addr, 32'h7000);
                end
                if (bus1.i_ready || bus1.d_ready) begin
                    check("p1_grant", {bus1.i_ready, bus1.d_ready}, 2'b01);
                    if (p1_q.size() == 0) begin
                        fail_now("p1_unexpected", "ready pulse with no expectation");
                    end else begin
                        exp = p1_q.pop_front();
                        check("p1_rdata", bus1.d_rdata, exp);
                    end
                end
                prev_mv = bus1.m_valid;
            end
        end
    end

    task automatic wait_pulse(input bit is_d);
        int n;
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!(is_d ? bus0.d_ready : bus0.i_ready) && n < 100);
        if (n >= 100) begin
            fail_now("wait_ready", "got no ready pulse, expected one within 100 cycles");
        end
    endtask

    task automatic do_fetch(input logic [31:0] addr);
        bus0.d_write = 1'b1;
        bus0.d_wdata = 32'hFFFFFFFF;
        bus0.d_wstb  = 4'hF;
        bus0.i_addr  = addr;
        bus0.i_valid = 1'b1;
        wait_pulse(1'b0);
        bus0.i_valid = 1'b0;
    endtask

    task automatic do_data(input logic [31:0] addr, input logic wr, input logic [31:0] wdata, input logic [3:0] wstb);
        bus0.d_addr  = addr;
        bus0.d_write = wr;
        bus0.d_wdata = wdata;
        bus0.d_wstb  = wstb;
        bus0.d_valid = 1'b1;
        wait_pulse(1'b1);
        bus0.d_valid = 1'b0;
    endtask

    task automatic check_quiet(input string name);
        check(name, {bus0.m_valid, bus0.i_ready, bus0.d_ready, bus0.bus_err}, 4'b0000);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish in time");
        $fatal(1, "global timeout");
    end

    initial begin
        int pulses;
        int n;
        int k;
        bus0.i_valid = 1'b0; bus0.i_addr = '0;
        bus0.d_valid = 1'b0; bus0.d_addr = '0; bus0.d_write = 1'b0; bus0.d_wdata = '0; bus0.d_wstb = '0;
        bus1.i_valid = 1'b0; bus1.i_addr = '0;
        bus1.d_valid = 1'b0; bus1.d_addr = '0; bus1.d_write = 1'b0; bus1.d_wdata = '0; bus1.d_wstb = '0;

        repeat (3) @(negedge clock);
        check("rst_ctl", {bus0.m_valid, bus0.m_write, bus0.i_ready, bus0.d_ready, bus0.bus_err}, 5'b0);
        check("rst_m", {bus0.m_addr, bus0.m_wdata, bus0.m_wstb}, 68'h0);
        check("rst_rdata", {bus0.i_rdata, bus0.d_rdata}, 64'h0);
        check("rst_dut1", {bus1.m_valid, bus1.i_ready, bus1.d_ready, bus1.bus_err}, 4'b0);
        reset = 1'b0;

        // Contention from reset: D first, then alternate, 3-cycle period.
        rd_from_addr = 1'b1;
        mem_wait     = 0;
        expect_txn(32'h3000, 1'b0, 32'h0, 4'hF, 1'b1, 32'h5A5A3000, 1'b0, 8'd1);
        expect_txn(32'h0400, 1'b0, 32'h0, 4'h0, 1'b0, 32'h5A5A0400, 1'b0, 8'd1);
        expect_txn(32'h3000, 1'b0, 32'h0, 4'hF, 1'b1, 32'h5A5A3000, 1'b0, 8'd1);
        expect_txn(32'h0400, 1'b0, 32'h0, 4'h0, 1'b0, 32'h5A5A0400, 1'b0, 8'd1);
        bus0.d_addr = 32'h3000; bus0.d_write = 1'b0; bus0.d_wdata = '0; bus0.d_wstb = 4'hF;
        bus0.i_addr = 32'h0400;
        bus0.i_valid = 1'b1;
        bus0.d_valid = 1'b1;
        pulses = 0; n = 0; k = 0;
        while (pulses < 4 && k < 200) begin
            @(negedge clock);
            k++;
            if (pulses > 0) n++;
            if (bus0.i_ready || bus0.d_ready) pulses++;
        end
        bus0.i_valid = 1'b0;
        bus0.d_valid = 1'b0;
        if (pulses < 4) fail_now("contention", $sformatf("got %0d pulses, expected 4", pulses));
        else check("period", n, 9);
        rd_from_addr = 1'b0;
        repeat (2) @(negedge clock);

        // Single fetch, one wait cycle; the idle data port's write fields must not leak.
        expect_txn(32'h100, 1'b0, 32'h0, 4'h0, 1'b0, 32'h00000013, 1'b0, 8'd2);
        mem_wait = 1; mem_rdata = 32'h00000013;
        do_fetch(32'h100);
        repeat (2) @(negedge clock);

        // Store with three wait cycles.
        expect_txn(32'h2000, 1'b1, 32'hCAFEF00D, 4'b0011, 1'b1, 32'h0BADF00D, 1'b0, 8'd4);
        mem_wait = 3; mem_rdata = 32'h0BADF00D;
        do_data(32'h2000, 1'b1, 32'hCAFEF00D, 4'b0011);
        @(negedge clock);
        check("i_rdata_hold", bus0.i_rdata, 32'h00000013);
        @(negedge clock);

        // Watchdog: memory never answers.
        expect_txn(32'h2400, 1'b0, 32'h0, 4'hF, 1'b1, 32'hDEADBEEF, 1'b1, 8'd8);
        mem_wait = -1;
        do_data(32'h2400, 1'b0, 32'h0, 4'hF);
        @(negedge clock);
        check("d_rdata_hold", bus0.d_rdata, 32'hDEADBEEF);
        @(negedge clock);

        // Normal access after a timeout must not flag an error.
        expect_txn(32'h2404, 1'b0, 32'h0, 4'hF, 1'b1, 32'h12345678, 1'b0, 8'd1);
        mem_wait = 0; mem_rdata = 32'h12345678;
        do_data(32'h2404, 1'b0, 32'h0, 4'hF);
        repeat (2) @(negedge clock);

        // Spurious m_ready while idle.
        force_rdy = 1'b1;
        repeat (3) begin
            @(negedge clock);
            check_quiet("spurious");
        end
        force_rdy = 1'b0;
        @(negedge clock);

        // Reset while a fetch is outstanding; stale m_ready afterwards.
        req_q.push_back('{addr: 32'h500, write: 1'b0, wdata: 32'h0, wstb: 4'h0});
        mem_wait = -1;
        bus0.i_addr  = 32'h500;
        bus0.i_valid = 1'b1;
        k = 0;
        do begin
            @(negedge clock);
            k++;
        end while (!bus0.m_valid && k < 20);
        if (!bus0.m_valid) fail_now("wait_m_valid", "got m_valid=0, expected 1 within 20 cycles");
        repeat (2) @(negedge clock);
        reset = 1'b1;
        bus0.i_valid = 1'b0;
        force_rdy = 1'b1;
        @(negedge clock);
        check_quiet("mid_reset");
        check("mid_reset_rdata", {bus0.i_rdata, bus0.d_rdata}, 64'h0);
        reset = 1'b0;
        repeat (2) begin
            @(negedge clock);
            check_quiet("stale_m_ready");
        end
        force_rdy = 1'b0;
        @(negedge clock);

        expect_txn(32'h600, 1'b0, 32'h0, 4'h0, 1'b0, 32'h00600093, 1'b0, 8'd1);
        mem_wait = 0; mem_rdata = 32'h00600093;
        do_fetch(32'h600);
        repeat (2) @(negedge clock);

        // Fixed data priority on dut1: I starves while D is held.
        repeat (3) p1_q.push_back(32'h5A5A7000);
        bus1.d_addr = 32'h7000; bus1.d_write = 1'b0; bus1.d_wdata = '0; bus1.d_wstb = 4'hF;
        bus1.i_addr = 32'h0800;
        bus1.i_valid = 1'b1;
        bus1.d_valid = 1'b1;
        pulses = 0; k = 0;
        while (pulses < 3 && k < 200) begin
            @(negedge clock);
            k++;
            if (bus1.i_ready || bus1.d_ready) pulses++;
        end
        bus1.i_valid = 1'b0;
        bus1.d_valid = 1'b0;
        if (pulses < 3) fail_now("p1_contention", $sformatf("got %0d pulses, expected 3", pulses));
        repeat (3) @(negedge clock);

        check("drain", {req_q.size(), rsp_q.size(), p1_q.size()}, 96'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
